// File: rtl/id_decode_sb_pkg.sv
// id_decode_sb_pkg: shared definitions for the instruction-decode stage.
//   - opcode constants (wildcard patterns use '?' and are matched with casez)
//   - class-bit layout cls_t: inte, lgc (logic class), shift, ld, st, br, set, und
//   - instruction field positions
//   - decode_class(): opcode -> class bits; writes_rd(): class -> destination write
package id_decode_sb_pkg;

  localparam int P_OPC  = 25;
  localparam int P_IMMF = 24;
  localparam int P_RD   = 20;
  localparam int P_RS   = 16;
  localparam int W_OPC  = 7;
  localparam int W_IMM  = 16;

  localparam logic [W_OPC-1:0] OPC_INTE   = 7'b0000???;
  localparam logic [W_OPC-1:0] OPC_SHL    = 7'b0001000;
  localparam logic [W_OPC-1:0] OPC_SHR    = 7'b0001001;
  localparam logic [W_OPC-1:0] OPC_SRA    = 7'b0001010;
  localparam logic [W_OPC-1:0] OPC_ROL    = 7'b0001100;
  localparam logic [W_OPC-1:0] OPC_ROR    = 7'b0001101;
  localparam logic [W_OPC-1:0] OPC_LOGIC  = 7'b00100??;
  localparam logic [W_OPC-1:0] OPC_SET0   = 7'b0010110;
  localparam logic [W_OPC-1:0] OPC_SET1   = 7'b0010111;
  localparam logic [W_OPC-1:0] OPC_LD     = 7'b0011000;
  localparam logic [W_OPC-1:0] OPC_ST     = 7'b0011001;
  localparam logic [W_OPC-1:0] OPC_BR     = 7'b00111??;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
    logic set;
    logic und;
  } cls_t;

  function automatic cls_t decode_class(input logic [W_OPC-1:0] opc);
    cls_t c;
    c = '0;
    casez (opc)
      OPC_INTE:                                 c.inte  = 1'b1;
      OPC_SHL, OPC_SHR, OPC_SRA, OPC_ROL, OPC_ROR: c.shift = 1'b1;
      OPC_LOGIC:                                c.lgc   = 1'b1;
      OPC_SET0, OPC_SET1:                       c.set   = 1'b1;
      OPC_LD:                                   c.ld    = 1'b1;
      OPC_ST:                                   c.st    = 1'b1;
      OPC_BR:                                   c.br    = 1'b1;
      default:                                  c.und   = 1'b1;
    endcase
    return c;
  endfunction

  // Stores, branches and undefined opcodes never produce a destination value.
  function automatic logic writes_rd(input cls_t c);
    return c.inte | c.lgc | c.shift | c.set | c.ld;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: N_REG x W_DATA general register file.
//   clk, rst      : clock, asynchronous active-high reset (zeroes every register)
//   we/waddr/wdata: single write port, written on the rising clock edge
//   raddr_a/rdata_a, raddr_b/rdata_b: two combinational read ports
module id_regfile
  import id_decode_sb_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int N_REG   = 16,
  parameter int W_RADDR = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [W_RADDR-1:0] waddr,
  input  logic [W_DATA-1:0]  wdata,
  input  logic [W_RADDR-1:0] raddr_a,
  output logic [W_DATA-1:0]  rdata_a,
  input  logic [W_RADDR-1:0] raddr_b,
  output logic [W_DATA-1:0]  rdata_b
);

  logic [W_DATA-1:0] mem [N_REG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/id_decode_sb.sv
// id_decode_sb: decode stage between IF and EX with register file, per-register
// busy scoreboard and valid/ready handshakes on both sides.
//   Upstream  : in_valid_i/in_ready_o, inst_i, pc_value_i
//   Control   : flush_i drops the held instruction and blocks acceptance
//   Writeback : wb_i, wb_r_i, wb_data_i (register write + busy-bit clear)
//   Downstream: out_valid_o/out_ready_i, class bits ctrl_*_o/und_o, immf_o,
//               rd_addr_o, rd_value_o, rs_value_o, imm_value_o, pc_value_o, opcode_o
// Build option: define ID_BYPASS_EN to forward a same-cycle write-back into the
// hazard check and operand read, letting a dependent instruction issue in the
// write-back cycle instead of one cycle later.
module id_decode_sb
  import id_decode_sb_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int N_REG   = 16,
  parameter int W_RADDR = 4,
  parameter int W_PC    = 16,
  parameter int W_INST  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W_INST-1:0]  inst_i,
  input  logic [W_PC-1:0]    pc_value_i,
  input  logic               flush_i,
  input  logic               wb_i,
  input  logic [W_RADDR-1:0] wb_r_i,
  input  logic [W_DATA-1:0]  wb_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               ctrl_inte_o,
  output logic               ctrl_logic_o,
  output logic               ctrl_shift_o,
  output logic               ctrl_ld_o,
  output logic               ctrl_st_o,
  output logic               ctrl_br_o,
  output logic               ctrl_set_o,
  output logic               und_o,
  output logic               immf_o,
  output logic [W_RADDR-1:0] rd_addr_o,
  output logic [W_DATA-1:0]  rd_value_o,
  output logic [W_DATA-1:0]  rs_value_o,
  output logic [W_DATA-1:0]  imm_value_o,
  output logic [W_PC-1:0]    pc_value_o,
  output logic [W_OPC-1:0]   opcode_o
);

  function automatic logic [N_REG-1:0] onehot(input logic [W_RADDR-1:0] a);
    return {{(N_REG-1){1'b0}}, 1'b1} << a;
  endfunction

  // Shift amounts/masks are unsigned; every other class treats imm as signed.
  function automatic logic [W_DATA-1:0] extend_imm(input logic [W_IMM-1:0] imm,
                                                   input logic zext);
    logic signed [W_IMM-1:0] simm;
    simm = imm;
    if (zext) return {{(W_DATA-W_IMM){1'b0}}, imm};
    return W_DATA'(simm);
  endfunction

  // ---- stage p0: field extraction, decode, operand read, hazard ----
  logic [W_OPC-1:0]   opc_p0;
  logic               immf_p0;
  logic [W_RADDR-1:0] rd_p0;
  logic [W_RADDR-1:0] rs_p0;
  logic [W_IMM-1:0]   imm16_p0;
  cls_t               cls_p0;
  logic               uses_rs_p0;
  logic [W_DATA-1:0]  rf_a_p0, rf_b_p0;
  logic [W_DATA-1:0]  rdv_p0, rsv_p0;
  logic [N_REG-1:0]   busy, busy_chk, wb_vec, set_vec;
  logic               held_hit_p0, hazard_p0, accept_p0, leave_p1;

  // held output register (stage p1)
  logic               vld_p1;
  cls_t               cls_p1;
  logic               immf_p1;
  logic [W_RADDR-1:0] rd_p1;
  logic [W_DATA-1:0]  rdv_p1, rsv_p1, imm_p1;
  logic [W_PC-1:0]    pc_p1;
  logic [W_OPC-1:0]   opc_p1;
  logic               wr_p1;

  assign opc_p0     = inst_i[P_OPC +: W_OPC];
  assign immf_p0    = inst_i[P_IMMF];
  assign rd_p0      = inst_i[P_RD +: W_RADDR];
  assign rs_p0      = inst_i[P_RS +: W_RADDR];
  assign imm16_p0   = inst_i[W_IMM-1:0];
  assign cls_p0     = decode_class(opc_p0);
  assign uses_rs_p0 = ~immf_p0;

  id_regfile #(
    .W_DATA (W_DATA),
    .N_REG  (N_REG),
    .W_RADDR(W_RADDR)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_i),
    .waddr  (wb_r_i),
    .wdata  (wb_data_i),
    .raddr_a(rd_p0),
    .rdata_a(rf_a_p0),
    .raddr_b(rs_p0),
    .rdata_b(rf_b_p0)
  );

  assign wb_vec = wb_i ? onehot(wb_r_i) : '0;

`ifdef ID_BYPASS_EN
  assign busy_chk = busy & ~wb_vec;
  assign rdv_p0   = (wb_i && (wb_r_i == rd_p0)) ? wb_data_i : rf_a_p0;
  assign rsv_p0   = (wb_i && (wb_r_i == rs_p0)) ? wb_data_i : rf_b_p0;
`else
  assign busy_chk = busy;
  assign rdv_p0   = rf_a_p0;
  assign rsv_p0   = rf_b_p0;
`endif

  // The held instruction has not marked its rd busy yet (that happens when it
  // leaves), so it is compared directly against the incoming operands.
  assign wr_p1       = writes_rd(cls_p1);
  assign held_hit_p0 = vld_p1 & wr_p1 &
                       ((rd_p1 == rd_p0) | (uses_rs_p0 & (rd_p1 == rs_p0)));
  assign hazard_p0   = busy_chk[rd_p0] | (uses_rs_p0 & busy_chk[rs_p0]) | held_hit_p0;

  assign in_ready_o = (~vld_p1 | out_ready_i) & ~hazard_p0 & ~flush_i;
  assign accept_p0  = in_valid_i & in_ready_o;

  // A flushed instruction is discarded, so it must not claim its destination.
  assign leave_p1 = vld_p1 & out_ready_i & ~flush_i;
  assign set_vec  = (leave_p1 & wr_p1) ? onehot(rd_p1) : '0;

  // Set is applied after clear so a same-cycle set/clear on one register keeps it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~wb_vec) | set_vec;
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      cls_p1  <= '0;
      immf_p1 <= 1'b0;
      rd_p1   <= '0;
      rdv_p1  <= '0;
      rsv_p1  <= '0;
      imm_p1  <= '0;
      pc_p1   <= '0;
      opc_p1  <= '0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      cls_p1  <= cls_p0;
      immf_p1 <= immf_p0;
      rd_p1   <= rd_p0;
      rdv_p1  <= rdv_p0;
      rsv_p1  <= rsv_p0;
      imm_p1  <= extend_imm(imm16_p0, cls_p0.shift);
      pc_p1   <= pc_value_i;
      opc_p1  <= opc_p0;
    end else if (out_ready_i || flush_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid_o  = vld_p1;
  assign ctrl_inte_o  = cls_p1.inte;
  assign ctrl_logic_o = cls_p1.lgc;
  assign ctrl_shift_o = cls_p1.shift;
  assign ctrl_ld_o    = cls_p1.ld;
  assign ctrl_st_o    = cls_p1.st;
  assign ctrl_br_o    = cls_p1.br;
  assign ctrl_set_o   = cls_p1.set;
  assign und_o        = cls_p1.und;
  assign immf_o       = immf_p1;
  assign rd_addr_o    = rd_p1;
  assign rd_value_o   = rdv_p1;
  assign rs_value_o   = rsv_p1;
  assign imm_value_o  = imm_p1;
  assign pc_value_o   = pc_p1;
  assign opcode_o     = opc_p1;

endmodule

// File: tb/tb_id_decode_sb.sv
`timescale 1ns/1ps
module tb_id_decode_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inst_i = '0;
  logic [15:0] pc_value_i = '0;
  logic        flush_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [3:0]  wb_r_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o;
  logic        ctrl_st_o, ctrl_br_o, ctrl_set_o, und_o, immf_o;
  logic [3:0]  rd_addr_o;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [15:0] pc_value_o;
  logic [6:0]  opcode_o;

  id_decode_sb dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .pc_value_i(pc_value_i), .flush_i(flush_i),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
    .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o),
    .ctrl_set_o(ctrl_set_o), .und_o(und_o), .immf_o(immf_o),
    .rd_addr_o(rd_addr_o), .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
    .imm_value_o(imm_value_o), .pc_value_o(pc_value_o), .opcode_o(opcode_o)
  );

  always #5 clk = ~clk;

  // class bits ordered inte, logic, shift, ld, st, br, set, und
  localparam logic [7:0] CLS_INTE  = 8'h80;
  localparam logic [7:0] CLS_SHIFT = 8'h20;
  localparam logic [7:0] CLS_UND   = 8'h01;

  typedef struct packed {
    logic [7:0]  cls;
    logic        immf;
    logic [3:0]  rd;
    logic [31:0] rdv;
    logic [31:0] rsv;
    logic [31:0] imm;
    logic [15:0] pc;
    logic [6:0]  opc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t mon_e, mon_a;
  int   w;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic immf,
                                          input logic [3:0] rd, input logic [3:0] rs,
                                          input logic [15:0] imm);
    return {opc, immf, rd, rs, imm};
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] cls, input logic immf, input logic [3:0] rd,
                                  input logic [31:0] rdv, input logic [31:0] rsv,
                                  input logic [31:0] imm, input logic [15:0] pc,
                                  input logic [6:0] opc);
    exp_t e;
    e = {cls, immf, rd, rdv, rsv, imm, pc, opc};
    return e;
  endfunction

  function automatic logic [31:0] rv(input int k);
    return 32'h1000_0000 + k;
  endfunction

  // Offers one instruction; waited = cycles it sat with in_ready_o low.
  task automatic send(input logic [31:0] inst, input logic [15:0] pc, input bit push,
                      input exp_t e, output int waited);
    if (push) q.push_back(e);
    inst_i = inst; pc_value_i = pc; in_valid_i = 1'b1; waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      waited++;
      if (waited >= 50) break;
    end
    if (waited >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no in_ready_o in 50 cycles, required acceptance (pc %0h)", pc);
      if (push) q.delete(q.size() - 1);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wbw(input logic [3:0] r, input logic [31:0] d);
    wb_i = 1'b1; wb_r_i = r; wb_data_i = d;
    @(posedge clk); #1;
    wb_i = 1'b0;
  endtask

  // Monitor: every output handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      mon_a = {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o,
               ctrl_set_o, und_o, immf_o, rd_addr_o, rd_value_o, rs_value_o, imm_value_o,
               pc_value_o, opcode_o};
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got output %0h, required no output", mon_a);
      end else begin
        mon_e = q.pop_front();
        chk("out_fields", mon_a, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, required finish");
    $fatal(1);
  end

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_outputs", {out_valid_o, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o,
                        ctrl_st_o, ctrl_br_o, ctrl_set_o, und_o, immf_o, rd_addr_o,
                        rd_value_o, rs_value_o, imm_value_o, pc_value_o, opcode_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready_o, 1);
    @(posedge clk); #1;

    // preload r[k] = 0x1000_0000 + k
    for (int k = 0; k < 16; k++) wbw(4'(k), rv(k));

    // back-to-back independent
    out_ready_i = 1'b1;
    send(mk_inst(7'h00, 0, 4'd1, 4'd2, 16'h0000), 16'h0100, 1,
         mk_exp(CLS_INTE, 0, 4'd1, rv(1), rv(2), 32'h0, 16'h0100, 7'h00), w);
    chk("b2b_first_wait", w, 0);
    send(mk_inst(7'h00, 0, 4'd3, 4'd4, 16'h0000), 16'h0104, 1,
         mk_exp(CLS_INTE, 0, 4'd3, rv(3), rv(4), 32'h0, 16'h0104, 7'h00), w);
    chk("b2b_second_wait", w, 0);

    // RAW/WAW on r1 (busy from the first instruction)
    q.push_back(mk_exp(CLS_INTE, 0, 4'd1, 32'h1234, 32'h1234, 32'h0, 16'h0200, 7'h01));
    inst_i = mk_inst(7'h01, 0, 4'd1, 4'd1, 16'h0000); pc_value_i = 16'h0200; in_valid_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("raw_stall", in_ready_o, 0);
    end
    @(posedge clk); #1;
    wb_i = 1'b1; wb_r_i = 4'd1; wb_data_i = 32'h1234;
    @(negedge clk);
`ifdef ID_BYPASS_EN
    chk("raw_wb_cycle_ready", in_ready_o, 1);
    @(posedge clk); #1;
    wb_i = 1'b0; in_valid_i = 1'b0;
`else
    chk("raw_wb_cycle_ready", in_ready_o, 0);
    @(posedge clk); #1;
    wb_i = 1'b0;
    @(negedge clk);
    chk("raw_next_cycle_ready", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    wbw(4'd1, rv(1));

    // backpressure
    out_ready_i = 1'b0;
    send(mk_inst(7'h00, 0, 4'd6, 4'd7, 16'h0000), 16'h0300, 1,
         mk_exp(CLS_INTE, 0, 4'd6, rv(6), rv(7), 32'h0, 16'h0300, 7'h00), w);
    chk("bp_first_wait", w, 0);
    q.push_back(mk_exp(CLS_INTE, 0, 4'd8, rv(8), rv(9), 32'h0, 16'h0304, 7'h00));
    inst_i = mk_inst(7'h00, 0, 4'd8, 4'd9, 16'h0000); pc_value_i = 16'h0304; in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", in_ready_o, 0);
      chk("bp_hold", {out_valid_o, rd_addr_o, pc_value_o, rd_value_o, rs_value_o},
                     {1'b1, 4'd6, 16'h0300, rv(6), rv(7)});
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;

    // immediates: shift zero-extends and ignores busy r3; add sign-extends
    send(mk_inst(7'h08, 1, 4'd10, 4'd3, 16'h8000), 16'h0400, 1,
         mk_exp(CLS_SHIFT, 1, 4'd10, rv(10), rv(3), 32'h0000_8000, 16'h0400, 7'h08), w);
    chk("shift_imm_wait", w, 0);
    send(mk_inst(7'h00, 0, 4'd11, 4'd12, 16'h8000), 16'h0404, 1,
         mk_exp(CLS_INTE, 0, 4'd11, rv(11), rv(12), 32'hFFFF_8000, 16'h0404, 7'h00), w);
    chk("add_imm_wait", w, 0);

    // undefined opcode: passes through, claims no register
    send(mk_inst(7'h7F, 0, 4'd13, 4'd14, 16'hFFFF), 16'h0500, 1,
         mk_exp(CLS_UND, 0, 4'd13, rv(13), rv(14), 32'hFFFF_FFFF, 16'h0500, 7'h7F), w);
    chk("und_wait", w, 0);
    @(posedge clk); #1;
    send(mk_inst(7'h00, 0, 4'd13, 4'd13, 16'h0000), 16'h0504, 1,
         mk_exp(CLS_INTE, 0, 4'd13, rv(13), rv(13), 32'h0, 16'h0504, 7'h00), w);
    chk("und_no_busy", w, 0);
    @(posedge clk); #1;

    // flush a held add r5
    out_ready_i = 1'b0;
    send(mk_inst(7'h00, 0, 4'd5, 4'd0, 16'h0005), 16'h0600, 0,
         mk_exp(CLS_INTE, 0, 4'd5, rv(5), rv(0), 32'h5, 16'h0600, 7'h00), w);
    flush_i = 1'b1;
    inst_i = mk_inst(7'h00, 0, 4'd12, 4'd2, 16'h0000); pc_value_i = 16'h0608; in_valid_i = 1'b1;
    @(negedge clk);
    chk("flush_held", {out_valid_o, rd_addr_o, pc_value_o}, {1'b1, 4'd5, 16'h0600});
    chk("flush_blocks_accept", in_ready_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_clears_valid", out_valid_o, 0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(mk_inst(7'h00, 0, 4'd5, 4'd5, 16'h0000), 16'h0604, 1,
         mk_exp(CLS_INTE, 0, 4'd5, rv(5), rv(5), 32'h0, 16'h0604, 7'h00), w);
    chk("flush_no_busy", w, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_decode_sb.md
# id_decode_sb

Parametrised instruction-decode stage with an integrated register file, per-register scoreboard and valid/ready handshakes on both sides. It sits between IF and EX. It decodes the 7-bit opcode into class control bits, reads both operands and builds the immediate. It holds back instructions with RAW/WAW hazards until the write-back stage clears them, replacing the former global stall chain with backpressure.

## Interface
- W_DATA, 32, register/operand data width
- N_REG, 16, number of general registers
- W_RADDR, 4, register address width; must satisfy 2**W_RADDR == N_REG
- W_PC, 16, program-counter width
- W_INST, 32, instruction width (fixed fields below assume 32)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  instruction available from IF
- in_ready_o  out  1  ID accepts instruction this cycle
- inst_i  in  W_INST  instruction: [31:25] opcode, [24] immf, [23:20] rd, [19:16] rs, [15:0] imm
- pc_value_i  in  W_PC  PC of inst_i
- flush_i  in  1  discard held and incoming instruction
- wb_i  in  1  write-back enable
- wb_r_i  in  W_RADDR  write-back register
- wb_data_i  in  W_DATA  write-back data
- out_valid_o  out  1  decoded instruction valid
- out_ready_i  in  1  EX accepts decoded instruction
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o, ctrl_set_o, und_o  out  1 each  class bits
- immf_o  out  1  use immediate instead of rs
- rd_addr_o  out  W_RADDR  destination address
- rd_value_o, rs_value_o  out  W_DATA  operand values
- imm_value_o  out  W_DATA  extended immediate
- pc_value_o  out  W_PC; opcode_o  out  7

## Operation
- Decode: 0000xxx → inte; 0001000/1001/1010/1100/1101 → shift; 00100xx → logic; 0010110/0010111 → set; 0011000 → ld; 0011001 → st; 00111xx → br; all others → und.
- writes_rd = inte|logic|shift|set|ld. st, br and und write nothing.
- Immediate: shift class zero-extends imm[15:0]; all other classes sign-extend it to W_DATA.
- uses_rs = ~immf. rd is always checked.
- Scoreboard: one busy bit per register.
  - A bit is set when a writes_rd instruction leaves ID (out_valid_o & out_ready_i).
  - A bit is cleared on wb_i for wb_r_i.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard on the incoming instruction if any of:
  - busy[rd];
  - uses_rs & busy[rs];
  - the held output is valid, writes_rd, and its rd_addr_o equals the incoming rd, or equals the incoming rs when uses_rs.
- in_ready_o = (~out_valid_o | out_ready_i) & ~hazard & ~flush_i.
- On accept: the output register loads all decode results and operands, and out_valid_o=1. Otherwise, if out_ready_i=1, out_valid_o=0. Otherwise outputs hold.
- flush_i: out_valid_o←0 next edge and nothing is accepted. The scoreboard is untouched, because a flushed instruction never set a bit.
- und instructions pass through with und_o=1 and never set a busy bit.
- Register file: written on every clk edge with wb_i. Reads are combinational.

## Timing
- Latency: accept at edge n → out_valid_o high after edge n.
- Full throughput: one instruction per cycle when there is no hazard and out_ready_i=1.
- Output fields are stable while out_valid_o=1 and out_ready_i=0.
- Reset (async, rst=1): out_valid_o=0, all ctrl/und/immf=0, all value/address/pc/opcode outputs=0, scoreboard cleared, register file zeroed. in_ready_o=1 once rst deasserts.
- Reset mid-operation discards the held instruction and all busy bits.

## Configuration
- ID_BYPASS_EN defined:
  - A same-cycle wb_i to a register masks its busy bit in the hazard check.
  - The operand mux forwards wb_data_i to rd/rs when the address matches.
  - A dependent instruction is accepted in the write-back cycle.
- Undefined:
  - No forwarding; the busy bit must be clear at the edge.
  - A dependent instruction is accepted one cycle after the write-back.

## Structure
- Shared package holds:
  - opcode constants;
  - class-bit layout (inte, logic, shift, ld, st, br, set, und);
  - field positions (P_OPC=25, P_IMMF=24, P_RD=20, P_RS=16).
- Sub-module id_regfile holds N_REG×W_DATA storage, two combinational read ports, one write port and async reset.
- Decode, scoreboard, hazard, bypass and output register live in the top module.

## Test plan
- Reset: rst=1 for 2 cycles → out_valid_o=0, every output 0, in_ready_o=1 after release.
- Back-to-back independent: opcode 0000000 rd=1 rs=2, then rd=3 rs=4, out_ready_i=1 → out_valid_o two consecutive cycles, ctrl_inte_o=1, rd_addr_o=1 then 3.
- RAW: write r1 then read r1, no wb → in_ready_o=0. Then wb_i=1, wb_r_i=1, wb_data_i=0x1234:
  - with ID_BYPASS_EN: accepted that cycle, rd_value_o=0x1234 next cycle;
  - without: accepted one cycle later.
- Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1 → outputs unchanged, in_ready_o=0; release → next instruction on the following cycle.
- Immediate:
  - shift 0001000, immf=1, imm=0x8000 → imm_value_o=0x00008000, busy[rs] ignored;
  - add with imm=0x8000 → 0xFFFF8000.
- Undefined/flush:
  - opcode 0x7F → und_o=1, no busy bit set;
  - flush_i while holding a valid add r5 → out_valid_o=0, busy[5] stays 0.
